chunk_fetcher: RTL and testbench

- Sits directly upstream of the broadcast stage and answers its chunk requests.
- On a start command, streams a block of `NUM_CHUNKS` chunks from a word-wide read port.
- Assembles each chunk into a `CHUNK_SIZE`-byte register, then hands it over with a one-cycle `o_ready` pulse per request.
- Flags the final chunk with `o_done` so the broadcaster can finish its sequence.

---
 rtl/chunk_fetcher_if.sv | 27 ++
 rtl/chunk_fetcher.sv | 157 +++++++++++++++
 tb/tb_chunk_fetcher.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_fetcher_if.sv
// Word-wide read port between chunk_fetcher (master) and memory (slave).
//   mem_rd_en    master->slave  read request
//   mem_addr     master->slave  byte address of the requested word
//   mem_rd_rdy   slave->master  request accepted this cycle
//   mem_rd_valid slave->master  read data valid (in order, any latency)
//   mem_rd_data  slave->master  returned word, byte 0 at the lowest address
interface chunk_fetcher_if #(
  parameter int unsigned BYTE       = 8,
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                               mem_rd_en;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic                               mem_rd_rdy;
  logic                               mem_rd_valid;
  logic [WORD_BYTES-1:0][BYTE-1:0]    mem_rd_data;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_rdy, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_rdy, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/chunk_fetcher.sv
// Streams NUM_CHUNKS chunks from a word-wide read port, assembles each into a
// CHUNK_SIZE-byte register and hands it to the broadcaster on request.
//   clk, rstn      clock, asynchronous active-low reset
//   i_start        start pulse (honoured only when idle)
//   i_base_addr    byte address of chunk 0, sampled on start
//   i_num_chunks   chunks to deliver, sampled on start (0 ignored)
//   i_req          chunk request from the broadcaster
//   o_ready        one-cycle pulse, o_data holds a valid chunk
//   o_data         assembled chunk
//   o_done         pulses with o_ready of the last chunk
//   o_busy         high from accepted start until the last delivery
//   mem            read port (master side)
module chunk_fetcher #(
  parameter int unsigned BYTE       = 8,
  parameter int unsigned CHUNK_SIZE = 1024,
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [CNT_WIDTH-1:0]             i_num_chunks,
  input  logic                             i_req,
  output logic                             o_ready,
  output logic [CHUNK_SIZE-1:0][BYTE-1:0]  o_data,
  output logic                             o_done,
  output logic                             o_busy,
  chunk_fetcher_if.master                  mem
);

  localparam int unsigned           WPC       = CHUNK_SIZE / WORD_BYTES;
  localparam int unsigned           IDX_W     = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [CNT_WIDTH-1:0]  WPC_C     = CNT_WIDTH'(WPC);
  localparam logic [CNT_WIDTH-1:0]  ONE_C     = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DELIVER} state_t;

  state_t                 state, state_nxt;
  logic                   req_pend, req_nxt;
  logic [CNT_WIDTH-1:0]   issued_cnt, issued_nxt;
  logic [CNT_WIDTH-1:0]   recv_cnt, recv_nxt;
  logic [CNT_WIDTH-1:0]   chunk_idx, chunk_nxt;
  logic [CNT_WIDTH-1:0]   num_chunks, num_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
  logic                   rd_en_q, rd_en_nxt;
  logic                   busy_nxt, ready_nxt, done_nxt;
  logic                   cap_en_c;
  logic [IDX_W-1:0]       wr_byte_c;

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign wr_byte_c     = IDX_W'(32'(recv_cnt) * WORD_BYTES);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, counters and next values of the registered outputs
  always_comb begin
    state_nxt  = state;
    req_nxt    = req_pend | i_req;
    issued_nxt = issued_cnt;
    recv_nxt   = recv_cnt;
    chunk_nxt  = chunk_idx;
    num_nxt    = num_chunks;
    addr_nxt   = addr_q;
    busy_nxt   = o_busy;
    cap_en_c   = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_start && (i_num_chunks != '0)) begin
          state_nxt  = FETCH;
          busy_nxt   = 1'b1;
          addr_nxt   = i_base_addr;
          num_nxt    = i_num_chunks;
          chunk_nxt  = '0;
          issued_nxt = '0;
          recv_nxt   = '0;
        end
      end
      FETCH: begin
        // addr_q runs contiguously, so after the last issue it already
        // points at the first word of the next chunk
        if (rd_en_q && mem.mem_rd_rdy) begin
          issued_nxt = issued_cnt + ONE_C;
          addr_nxt   = addr_q + WORD_STEP;
        end
        if (mem.mem_rd_valid && (recv_cnt != WPC_C)) begin
          cap_en_c = 1'b1;
          recv_nxt = recv_cnt + ONE_C;
        end
        if (recv_cnt == WPC_C) state_nxt = HOLD;
      end
      HOLD: begin
        if (req_pend || i_req) state_nxt = DELIVER;
      end
      DELIVER: begin
        // a request arriving in the delivery cycle is consumed by it
        req_nxt = 1'b0;
        if (chunk_idx == num_chunks - ONE_C) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt  = FETCH;
          chunk_nxt  = chunk_idx + ONE_C;
          issued_nxt = '0;
          recv_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    rd_en_nxt = (state_nxt == FETCH) && (issued_nxt != WPC_C);
    ready_nxt = (state_nxt == DELIVER);
    done_nxt  = ready_nxt && (chunk_nxt == num_nxt - ONE_C);
  end

  // Counters, latches and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_pend   <= 1'b0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      chunk_idx  <= '0;
      num_chunks <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      o_busy     <= 1'b0;
      o_ready    <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      req_pend   <= req_nxt;
      issued_cnt <= issued_nxt;
      recv_cnt   <= recv_nxt;
      chunk_idx  <= chunk_nxt;
      num_chunks <= num_nxt;
      addr_q     <= addr_nxt;
      rd_en_q    <= rd_en_nxt;
      o_busy     <= busy_nxt;
      o_ready    <= ready_nxt;
      o_done     <= done_nxt;
    end
  end

  // Chunk assembly buffer, one word per read return
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         o_data <= '0;
    else if (cap_en_c) o_data[wr_byte_c +: WORD_BYTES] <= mem.mem_rd_data;
  end

endmodule

// File: tb/tb_chunk_fetcher.sv
// Self-checking bench for chunk_fetcher: random memory contents and random
// transactions, expected chunks/addresses computed directly from memory.
module tb_chunk_fetcher;
  localparam int unsigned BYTE = 8;
  localparam int unsigned CS   = 32;
  localparam int unsigned WB   = 8;
  localparam int unsigned AW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned WPC  = CS / WB;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     i_start;
  logic [AW-1:0]            i_base_addr;
  logic [CW-1:0]            i_num_chunks;
  logic                     i_req;
  logic                     o_ready;
  logic [CS-1:0][BYTE-1:0]  o_data;
  logic                     o_done;
  logic                     o_busy;

  chunk_fetcher_if #(.BYTE(BYTE), .WORD_BYTES(WB), .ADDR_WIDTH(AW)) mif ();

  chunk_fetcher #(
    .BYTE(BYTE), .CHUNK_SIZE(CS), .WORD_BYTES(WB), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_chunks(i_num_chunks), .i_req(i_req), .o_ready(o_ready), .o_data(o_data),
    .o_done(o_done), .o_busy(o_busy), .mem(mif)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int unsigned       due;
    logic [WB*BYTE-1:0] data;
  } ret_t;

  ret_t             pend[$];
  logic [7:0]       mem_b [4096];
  int unsigned      cyc = 0;
  int unsigned      lat = 1;
  bit               bp = 1'b0;
  logic [AW-1:0]    addr_q[$];
  logic [255:0]     data_q[$];
  logic             done_q[$];
  int unsigned      rcyc_q[$];
  int unsigned      busy_rise = 0;
  int unsigned      hold_viol = 0;
  int unsigned      stray_done = 0;
  int unsigned      stray_all = 0;
  int unsigned      total = 0;
  int unsigned      bad = 0;
  logic             prev_stall = 1'b0;
  logic             prev_busy = 1'b0;
  logic [AW-1:0]    prev_addr = '0;

  function automatic logic [WB*BYTE-1:0] word_at(input logic [AW-1:0] a);
    logic [WB-1:0][7:0] w;
    for (int b = 0; b < int'(WB); b++) w[b] = mem_b[12'(a + AW'(b))];
    return w;
  endfunction

  function automatic logic [255:0] exp_chunk(input logic [AW-1:0] base, input int k);
    logic [CS-1:0][7:0] c;
    for (int i = 0; i < int'(CS); i++) c[i] = mem_b[12'(base + AW'(k * int'(CS) + i))];
    return c;
  endfunction

  // Memory model: accepted requests return in order after 'lat' cycles
  initial begin
    mif.mem_rd_rdy   = 1'b1;
    mif.mem_rd_valid = 1'b0;
    mif.mem_rd_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mif.mem_rd_rdy = bp ? cyc[0] : 1'b1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        mif.mem_rd_valid = 1'b1;
        mif.mem_rd_data  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        mif.mem_rd_valid = 1'b0;
      end
    end
  end

  // Monitor: sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rstn === 1'b1) begin
      if (mif.mem_rd_en && mif.mem_rd_rdy) begin
        addr_q.push_back(mif.mem_addr);
        pend.push_back('{due: cyc + lat, data: word_at(mif.mem_addr)});
      end
      if (prev_stall && mif.mem_rd_en && (mif.mem_addr !== prev_addr)) hold_viol++;
      prev_stall = mif.mem_rd_en && !mif.mem_rd_rdy;
      prev_addr  = mif.mem_addr;
      if (o_ready) begin
        data_q.push_back(o_data);
        done_q.push_back(o_done);
        rcyc_q.push_back(cyc);
      end
      if (o_done && !o_ready) begin
        stray_done++;
        stray_all++;
      end
      if (o_busy && !prev_busy) busy_rise = cyc;
      prev_busy = o_busy;
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] base, input int unsigned num);
    i_start      = 1'b1;
    i_base_addr  = base;
    i_num_chunks = CW'(num);
    tick();
    i_start      = 1'b0;
  endtask

  task automatic wait_readies(input int unsigned n, input int unsigned limit, input string tag);
    int unsigned k = 0;
    while (data_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk_i({tag, " ready count"}, data_q.size(), n);
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    done_q.delete();
    rcyc_q.delete();
    hold_viol  = 0;
    stray_done = 0;
  endtask

  // Compare delivered chunks and issued addresses with a block starting at base
  task automatic check_block(input string tag, input logic [AW-1:0] base, input int unsigned num);
    chk_i({tag, " readies"}, data_q.size(), num);
    for (int k = 0; k < int'(num); k++) begin
      if (k < data_q.size()) begin
        chk({tag, " data"}, data_q[k], exp_chunk(base, k));
        chk_i({tag, " done"}, 32'(done_q[k]), 32'(k == int'(num) - 1));
      end
    end
    chk_i({tag, " addr count"}, addr_q.size(), num * WPC);
    for (int j = 0; j < int'(num * WPC); j++)
      if (j < addr_q.size()) chk_i({tag, " addr"}, addr_q[j], base + AW'(j * int'(WB)));
    chk_i({tag, " addr hold"}, hold_viol, 32'd0);
    chk_i({tag, " stray done"}, stray_done, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_i({tag, " o_ready"}, 32'(o_ready), 32'd0);
    chk_i({tag, " o_done"}, 32'(o_done), 32'd0);
    chk_i({tag, " o_busy"}, 32'(o_busy), 32'd0);
    chk_i({tag, " mem_rd_en"}, 32'(mif.mem_rd_en), 32'd0);
    chk_i({tag, " mem_addr"}, mif.mem_addr, 32'd0);
    chk({tag, " o_data"}, o_data, 256'd0);
  endtask

  initial begin
    logic [AW-1:0] base;
    int unsigned   num;
    int unsigned   k;

    for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);
    rstn = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_chunks = '0; i_req = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // Single chunk, request raised shortly after reset
    rstn = 1'b1;
    tick();
    tick();
    pulse_req();
    start(32'h100, 1);
    wait_readies(1, 60, "single");
    chk_i("single busy drop", 32'(o_busy), 32'd0);
    chk_i("single ready width", 32'(o_ready), 32'd0);
    if (rcyc_q.size() != 0) chk_i("single latency", rcyc_q[0] - busy_rise, WPC + 3);
    check_block("single", 32'h100, 1);

    // Three chunks, request 5 cycles after each delivery
    clear_logs();
    pulse_req();
    start(32'h100, 3);
    for (int i = 1; i <= 3; i++) begin
      wait_readies(i, 80, "three");
      if (i < 3) begin
        repeat (4) tick();
        pulse_req();
      end
    end
    repeat (10) tick();
    check_block("three", 32'h100, 3);

    // Backpressure with 3-cycle latency, address wrapping across 2^32
    clear_logs();
    bp = 1'b1; lat = 3;
    pulse_req();
    start(32'hFFFF_FFE0, 2);
    wait_readies(1, 200, "bp");
    pulse_req();
    wait_readies(2, 200, "bp");
    repeat (5) tick();
    check_block("bp", 32'hFFFF_FFE0, 2);
    bp = 1'b0; lat = 1;

    // No request: chunk stays held until i_req
    clear_logs();
    start(32'h200, 1);
    repeat (12) tick();
    chk("hold data", o_data, exp_chunk(32'h200, 0));
    repeat (20) tick();
    chk("hold stable", o_data, exp_chunk(32'h200, 0));
    chk_i("hold no ready", data_q.size(), 32'd0);
    chk_i("hold busy", 32'(o_busy), 32'd1);
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk_i("hold ready next", 32'(o_ready), 32'd1);
    chk_i("hold done next", 32'(o_done), 32'd1);
    tick();

    // Zero-count start and start while busy
    clear_logs();
    start(32'h40, 0);
    repeat (5) tick();
    chk_i("zero busy", 32'(o_busy), 32'd0);
    chk_i("zero addrs", addr_q.size(), 32'd0);
    pulse_req();
    start(32'h300, 2);
    repeat (2) tick();
    start(32'h500, 1);
    wait_readies(1, 80, "busy start");
    pulse_req();
    wait_readies(2, 80, "busy start");
    repeat (8) tick();
    check_block("busy start", 32'h300, 2);

    // Reset after two words issued; stale returns must be ignored
    clear_logs();
    lat = 3;
    pulse_req();
    start(32'h600, 1);
    k = 0;
    while (addr_q.size() < 2 && k < 40) begin
      tick();
      k++;
    end
    chk_i("midrst issued", addr_q.size(), 32'd2);
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    chk_i("midrst idle busy", 32'(o_busy), 32'd0);
    chk_i("midrst no ready", data_q.size(), 32'd0);
    chk("midrst stale ignored", o_data, 256'd0);
    lat = 1;
    clear_logs();
    pulse_req();
    start(32'h700, 1);
    wait_readies(1, 80, "after rst");
    repeat (3) tick();
    check_block("after rst", 32'h700, 1);

    // Random transactions
    for (int it = 0; it < 5; it++) begin
      lat  = $urandom_range(1, 4);
      bp   = 1'($urandom_range(0, 1));
      base = $urandom;
      num  = $urandom_range(1, 3);
      clear_logs();
      pulse_req();
      start(base, num);
      for (int i = 1; i <= int'(num); i++) begin
        wait_readies(i, 300, "rand");
        if (i < int'(num)) begin
          repeat ($urandom_range(0, 6)) tick();
          pulse_req();
        end
      end
      repeat (8) tick();
      check_block("rand", base, num);
    end

    chk_i("global stray done", stray_all, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
